// File: rtl/tlb_plru.sv
// Set-associative TLB with per-set tree pseudo-LRU replacement and an ASID sweep.
// Latency: a command sampled at edge N responds in cycle N+1; array writes land at edge N+1.
// Backpressure: o_busy=1 during an ASID sweep (NUM_SETS cycles); commands seen then are dropped.
//
// Ports:
//   i_clk, i_reset_n              clock, async active-low reset
//   i_lookup_en / i_update_en / i_invalidate_en / i_invalidate_all_en / i_invalidate_asid_en
//                                 one-hot-0 commands, sampled only while o_busy=0
//   i_request_vpage_idx, i_request_asid   virtual page and address space of the request
//   i_update_ppage_idx, i_update_*        translation and attributes to install
//   o_lookup_hit, o_lookup_ppage_idx, o_lookup_*  lookup result (all zero on miss)
//   o_busy                        ASID sweep in progress
module tlb_plru #(
  parameter int NUM_ENTRIES   = 64,
  parameter int NUM_WAYS      = 4,
  parameter int PAGE_NUM_BITS = 20,
  parameter int ASID_WIDTH    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_lookup_en,
  input  logic                     i_update_en,
  input  logic                     i_invalidate_en,
  input  logic                     i_invalidate_all_en,
  input  logic                     i_invalidate_asid_en,
  input  logic [PAGE_NUM_BITS-1:0] i_request_vpage_idx,
  input  logic [ASID_WIDTH-1:0]    i_request_asid,
  input  logic [PAGE_NUM_BITS-1:0] i_update_ppage_idx,
  input  logic                     i_update_present,
  input  logic                     i_update_exe_writable,
  input  logic                     i_update_supervisor,
  input  logic                     i_update_global,
  output logic [PAGE_NUM_BITS-1:0] o_lookup_ppage_idx,
  output logic                     o_lookup_hit,
  output logic                     o_lookup_present,
  output logic                     o_lookup_exe_writable,
  output logic                     o_lookup_supervisor,
  output logic                     o_busy
);

  localparam int NUM_SETS  = NUM_ENTRIES / NUM_WAYS;
  localparam int SET_BITS  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int WAY_BITS  = $clog2(NUM_WAYS);
  localparam int TREE_BITS = NUM_WAYS - 1;

  typedef struct packed {
    logic [PAGE_NUM_BITS-1:0] vpage;
    logic [PAGE_NUM_BITS-1:0] ppage;
    logic                     present;
    logic                     exe_writable;
    logic                     supervisor;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  // Array state: valid/global/ASID/PLRU need per-way parallel access for the sweep.
  logic [NUM_WAYS-1:0]   r_valid  [NUM_SETS];
  logic [NUM_WAYS-1:0]   r_global [NUM_SETS];
  logic [TREE_BITS-1:0]  r_plru   [NUM_SETS];
  logic [ASID_WIDTH-1:0] r_asid_arr [NUM_SETS][NUM_WAYS];
  entry_t                r_entry  [NUM_SETS][NUM_WAYS];

  // Stage-1 command registers
  logic                     r_lkp_vld;
  logic                     r_upd_vld;
  logic                     r_inv_vld;
  logic [PAGE_NUM_BITS-1:0] r_vpage;
  logic [PAGE_NUM_BITS-1:0] r_ppage;
  logic [ASID_WIDTH-1:0]    r_asid;
  logic                     r_present;
  logic                     r_exe_wr;
  logic                     r_super;
  logic                     r_glb;

  // Sweep FSM
  state_t                r_state;
  logic [SET_BITS-1:0]   r_sweep_set;
  logic [ASID_WIDTH-1:0] r_sweep_asid;
  logic                  r_busy;

  logic                w_lkp_acc, w_upd_acc, w_inv_acc, w_inv_all_acc, w_inv_asid_acc;
  logic [4:0]          w_cmds;
  logic [SET_BITS-1:0] w_set;
  logic [NUM_WAYS-1:0] w_match;
  logic                w_hit;
  logic [WAY_BITS-1:0] w_hit_way;
  logic                w_free_vld;
  logic [WAY_BITS-1:0] w_free_way;
  logic [WAY_BITS-1:0] w_victim;
  logic [WAY_BITS-1:0] w_tgt_way;
  logic [NUM_WAYS-1:0] w_sweep_clr;
  entry_t              w_hit_ent;
  entry_t              w_new_ent;
  logic                w_lkp_hit;

  // Walk the tree from the root; each bit names the subtree holding the victim.
  function automatic logic [WAY_BITS-1:0] f_victim(input logic [TREE_BITS-1:0] tree);
    logic [WAY_BITS-1:0] way;
    int                  node;
    way  = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      way[WAY_BITS-1-lvl] = tree[node];
      node = 2 * node + 1 + (tree[node] ? 1 : 0);
    end
    return way;
  endfunction

  // Flip every node on the touched way's path to point at the other subtree.
  function automatic logic [TREE_BITS-1:0] f_touch(input logic [TREE_BITS-1:0] tree,
                                                   input logic [WAY_BITS-1:0]  way);
    logic [TREE_BITS-1:0] t;
    logic                 dir;
    int                   node;
    t    = tree;
    node = 0;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      dir     = way[WAY_BITS-1-lvl];
      t[node] = ~dir;
      node    = 2 * node + 1 + (dir ? 1 : 0);
    end
    return t;
  endfunction

  assign w_cmds         = {i_lookup_en, i_update_en, i_invalidate_en,
                           i_invalidate_all_en, i_invalidate_asid_en};
  assign w_lkp_acc      = i_lookup_en          & ~r_busy;
  assign w_upd_acc      = i_update_en          & ~r_busy;
  assign w_inv_acc      = i_invalidate_en      & ~r_busy;
  assign w_inv_all_acc  = i_invalidate_all_en  & ~r_busy;
  assign w_inv_asid_acc = i_invalidate_asid_en & ~r_busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lkp_vld <= 1'b0;
      r_upd_vld <= 1'b0;
      r_inv_vld <= 1'b0;
      r_vpage   <= '0;
      r_ppage   <= '0;
      r_asid    <= '0;
      r_present <= 1'b0;
      r_exe_wr  <= 1'b0;
      r_super   <= 1'b0;
      r_glb     <= 1'b0;
    end else begin
      r_lkp_vld <= w_lkp_acc;
      r_upd_vld <= w_upd_acc;
      r_inv_vld <= w_inv_acc;
      if (w_lkp_acc || w_upd_acc || w_inv_acc) begin
        r_vpage   <= i_request_vpage_idx;
        r_ppage   <= i_update_ppage_idx;
        r_asid    <= i_request_asid;
        r_present <= i_update_present;
        r_exe_wr  <= i_update_exe_writable;
        r_super   <= i_update_supervisor;
        r_glb     <= i_update_global;
      end
    end
  end

  // Stage-1 compare against the addressed set
  always_comb begin
    w_set      = r_vpage[SET_BITS-1:0];
    w_match    = '0;
    w_hit_way  = '0;
    w_free_vld = 1'b0;
    w_free_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      // A global install also claims any same-vpage entry regardless of its ASID.
      w_match[w] = r_valid[w_set][w] &&
                   (r_entry[w_set][w].vpage == r_vpage) &&
                   ((r_asid_arr[w_set][w] == r_asid) || r_global[w_set][w] ||
                    (r_upd_vld && r_glb));
      if (w_match[w]) w_hit_way = WAY_BITS'(w);
    end
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_set][w]) begin
        w_free_vld = 1'b1;
        w_free_way = WAY_BITS'(w);
      end
    end
    w_hit     = |w_match;
    w_victim  = f_victim(r_plru[w_set]);
    w_tgt_way = w_hit ? w_hit_way : (w_free_vld ? w_free_way : w_victim);
    w_hit_ent = r_entry[w_set][w_hit_way];
  end

  always_comb begin
    w_new_ent.vpage        = r_vpage;
    w_new_ent.ppage        = r_ppage;
    w_new_ent.present      = r_present;
    w_new_ent.exe_writable = r_exe_wr;
    w_new_ent.supervisor   = r_super;
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_sweep_clr[w] = (r_asid_arr[r_sweep_set][w] == r_sweep_asid) &&
                       !r_global[r_sweep_set][w];
    end
  end

  assign w_lkp_hit             = r_lkp_vld & w_hit;
  assign o_lookup_hit          = w_lkp_hit;
  assign o_lookup_ppage_idx    = w_lkp_hit ? w_hit_ent.ppage : '0;
  assign o_lookup_present      = w_lkp_hit & w_hit_ent.present;
  assign o_lookup_exe_writable = w_lkp_hit & w_hit_ent.exe_writable;
  assign o_lookup_supervisor   = w_lkp_hit & w_hit_ent.supervisor;
  assign o_busy                = r_busy;

  // Valid and PLRU. invalidate_all takes effect at its own sampling edge and
  // wins over a stage-1 update writing at that same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else if (w_inv_all_acc) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (r_upd_vld) begin
        r_valid[w_set][w_tgt_way] <= 1'b1;
        r_plru[w_set]             <= f_touch(r_plru[w_set], w_tgt_way);
      end else if (r_lkp_vld && w_hit) begin
        r_plru[w_set] <= f_touch(r_plru[w_set], w_hit_way);
      end
      if (r_inv_vld && w_hit) begin
        r_valid[w_set][w_hit_way] <= 1'b0;
      end
      // No stage-1 op can be live during a sweep, so these never collide.
      if (r_state == ST_SWEEP) begin
        r_valid[r_sweep_set] <= r_valid[r_sweep_set] & ~w_sweep_clr;
      end
    end
  end

  // Payload storage has no reset; valid qualifies it.
  always_ff @(posedge i_clk) begin
    if (r_upd_vld) begin
      r_entry[w_set][w_tgt_way]    <= w_new_ent;
      r_asid_arr[w_set][w_tgt_way] <= r_asid;
      r_global[w_set][w_tgt_way]   <= r_glb;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_sweep_set  <= '0;
      r_sweep_asid <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_inv_asid_acc) begin
            r_sweep_asid <= i_request_asid;
            r_sweep_set  <= '0;
            r_state      <= ST_SWEEP;
            r_busy       <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (r_sweep_set == SET_BITS'(NUM_SETS - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_sweep_set <= r_sweep_set + SET_BITS'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  a_cmd_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                 !r_busy |-> $onehot0(w_cmds))
    else $error("tlb_plru: more than one command asserted");

  a_busy_drop: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                r_busy |-> (w_cmds == '0))
    else $warning("tlb_plru: command ignored while busy");

  a_one_match: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                (r_lkp_vld || r_upd_vld || r_inv_vld) |-> $onehot0(w_match))
    else $error("tlb_plru: multiple ways match in one set");

endmodule

// File: doc/tlb_plru.md
# tlb_plru

Parametrised set-associative translation lookaside buffer for the instruction and data cache pipelines. It caches virtual-to-physical page translations tagged by ASID. Over the first-generation TLB it adds per-set tree pseudo-LRU replacement, preferential fill of invalid ways, and an ASID-selective invalidate that sweeps the array under a busy handshake. It sits in the cache tag stage; lookups resolve in one cycle.

## Interface
- NUM_ENTRIES, 64: total entries; must be a multiple of NUM_WAYS, and NUM_ENTRIES/NUM_WAYS (NUM_SETS) a power of two.
- NUM_WAYS, 4: associativity; must be a power of two and ≥2.
- PAGE_NUM_BITS, 20: width of virtual and physical page indices.
- ASID_WIDTH, 8: address space identifier width.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- lookup_en  in  1  translate request_vpage_idx/request_asid.
- update_en  in  1  install or overwrite a translation.
- invalidate_en  in  1  invalidate the single matching translation.
- invalidate_all_en  in  1  invalidate every entry.
- invalidate_asid_en  in  1  invalidate all non-global entries with ASID request_asid.
- request_vpage_idx  in  PAGE_NUM_BITS  virtual page; set index = low log2(NUM_SETS) bits.
- request_asid  in  ASID_WIDTH  request address space.
- update_ppage_idx  in  PAGE_NUM_BITS  physical page for update.
- update_present, update_exe_writable, update_supervisor, update_global  in  1 each  entry attributes for update. exe_writable means executable for the icache and writable for the dcache.
- lookup_ppage_idx  out  PAGE_NUM_BITS  translated page; 0 on miss.
- lookup_hit  out  1  translation found.
- lookup_present, lookup_exe_writable, lookup_supervisor  out  1 each  attributes of the hit entry; 0 on miss.
- busy  out  1  ASID sweep in progress; commands are not accepted.

## Operation
- Commands are one-hot-0 (asserted); they are sampled only when busy=0. Commands sampled while busy=1 are dropped, and an assertion fires.
- Match condition: valid && vpage equal && (ASID equal || entry global). For update, the stored entry's global bit is also OR'd with update_global, so a global install replaces any same-vpage entry.
- Lookup hit: the PLRU bits of the set are touched toward the hit way. A miss leaves PLRU unchanged.
- Update, target way: the hit way if a match exists. Otherwise the lowest-numbered invalid way of the set. Otherwise the PLRU victim.
- Update write: writes vpage, ASID, ppage and attributes, sets valid, and touches PLRU toward the written way.
- Invalidate: clears valid of the matching way. No match means no effect. PLRU unchanged.
- invalidate_all: clears every valid bit and resets all PLRU bits to 0.
- PLRU: NUM_WAYS-1 tree bits per set, held in flops. Bit=0 means the victim is in the left (lower-numbered) subtree. A touch sets the bits on the path to point away from the touched way.
- Valid, ASID and global bits are held in flops. Vpage, ppage and attributes may be in sram_1r1w with new-data read-during-write.
- FSM states:
  - IDLE: on invalidate_asid_en, latch request_asid, set the sweep counter to 0 and go to SWEEP.
  - SWEEP: each cycle, in set[counter], clear valid of every way whose ASID equals the latched ASID and global=0. Increment the counter. After set NUM_SETS-1, return to IDLE.
- More than one command asserted is an assertion error. More than one way matching in a set is an assertion error.

## Timing
- Reset: all valid=0, PLRU=0, FSM=IDLE, counter=0. Outputs: lookup_hit=0, all lookup_* = 0, busy=0.
- A command sampled at edge N produces its response on outputs during cycle N+1. The outputs are combinational from stage-1 registers.
- When no lookup, update or invalidate was sampled at edge N, lookup_hit=0 in cycle N+1.
- Update and invalidate compare in cycle N+1; the array write occurs at edge N+1.
- Bypass: a lookup at N+1 of an entry written by an update sampled at N must hit with the new data. A lookup at N+1 after an invalidate at N must miss.
- invalidate_all sampled at edge N: a lookup sampled at edge N+1 misses. A pending update write at edge N, from an update at N-1, is also cleared.
- invalidate_asid sampled at edge N:
  - busy=1 for cycles N+1 through N+NUM_SETS, and 0 in cycle N+NUM_SETS+1.
  - The first command accepted is the one sampled at edge N+NUM_SETS+1.
- Reset asserted mid-sweep: immediately returns to IDLE with busy=0 and all entries invalid.

## Test plan
- Reset, then lookup vpage 0x12345 with ASID 3 -> lookup_hit=0 and lookup_ppage_idx=0 the next cycle. busy=0.
- Update vpage 0x00010 → ppage 0xABCDE with ASID 1, present=1, writable=1; lookup on the very next cycle -> hit, ppage 0xABCDE, present=1, exe_writable=1, supervisor=0.
- Fill all 4 ways of set 0 (vpages 0x00, 0x10, 0x20, 0x30 at 64 entries). Look up 0x00 and 0x20, then update 0x40 -> replaces way 1 (0x10); lookup of 0x10 misses and lookup of 0x00 hits.
- Install entries in ASIDs 2 and 5 plus a global entry, then invalidate_asid 2:
  - busy high exactly 16 cycles.
  - Afterwards, ASID-2 entries miss while ASID-5 and global entries hit.
  - A lookup issued while busy returns lookup_hit=0.
- Update, then invalidate the same vpage/ASID, then lookup -> miss. A following update of the same set fills the freed way (lowest invalid).
- Start invalidate_asid, deassert reset_n on sweep cycle 5 -> busy=0 immediately and every prior entry misses after reset release.
